// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared constants and state encodings for the round-robin demux scheduler
package demux_sched_pkg;
  localparam int NUM_CH = 4;
  localparam int DEF_DW = 8;
  localparam int DEF_CNTW = 16;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first enabled channel at or after ptr, wrapping modulo 4
module rr_pick
  import demux_sched_pkg::*;
(
  input  logic [1:0]        ptr,
  input  logic [NUM_CH-1:0] mask,
  output logic [1:0]        pick,
  output logic              any
);
  logic [2:0] rot;
  logic [1:0] off;
  // rotate the mask so bit 0 is the pointer channel, then take the lowest set bit
  always_comb begin
    rot = 3'({mask, mask} >> ptr);
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    pick = ptr + off;
    any = |mask;
  end
endmodule

// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler: holds one item and delivers it to a round-robin chosen enabled channel
module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int CNTW = DEF_CNTW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] chan_en,
  output logic [NUM_CH-1:0] out_valid,
  output logic [DW-1:0]     out_data,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [CNTW-1:0]   sent_cnt
);
  logic [0:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d, tgt_q, tgt_d, pick;
  logic [DW-1:0] data_q, data_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic any, hold, acc, done;
  rr_pick u_pick (.ptr(ptr_q), .mask(chan_en), .pick(pick), .any(any));
  // outputs and next state; the target is latched at capture so chan_en edits never retarget
  always_comb begin
    hold = state_q == S_HOLD;
    in_ready = !hold && any;
    acc = in_valid && in_ready;
    done = hold && out_ready[tgt_q];
    out_valid = hold ? (4'b0001 << tgt_q) : 4'b0000;
    out_data = data_q;
    sel = hold ? tgt_q : ptr_q;
    busy = hold;
    sent_cnt = cnt_q;
    state_d = acc ? S_HOLD : done ? S_IDLE : state_q;
    tgt_d = acc ? pick : tgt_q;
    data_d = acc ? in_data : data_q;
    ptr_d = done ? tgt_q + 2'd1 : ptr_q;
    cnt_d = done ? cnt_q + CNTW'(1) : cnt_q;
  end
  // state registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      tgt_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      tgt_q <= tgt_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_demux_rr_scheduler.sv
// tb_demux_rr_scheduler: model-checked directed scenarios for the round-robin demux scheduler
module tb_demux_rr_scheduler;
  localparam int CW = 4;
  logic clk = 0, rst, in_valid, in_ready, busy;
  logic [7:0] in_data, out_data;
  logic [3:0] chan_en, out_valid, out_ready;
  logic [1:0] sel;
  logic [CW-1:0] sent_cnt;
  int pass_cnt = 0, total = 0, cyc = 0;
  int dlog[$];
  bit m_hold;
  int m_ptr, m_tgt, m_cnt;
  logic [7:0] m_data;

  demux_rr_scheduler #(.DW(8), .CNTW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .chan_en(chan_en), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sel(sel), .busy(busy), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int first(input int p, input logic [3:0] m);
    for (int k = 0; k < 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold <= 0; m_ptr <= 0; m_tgt <= 0; m_cnt <= 0; m_data <= 0;
    end else if (!m_hold) begin
      if (in_valid && chan_en != 0) begin
        m_hold <= 1; m_tgt <= first(m_ptr, chan_en); m_data <= in_data;
      end
    end else if (out_ready[m_tgt]) begin
      m_hold <= 0; m_ptr <= (m_tgt + 1) % 4; m_cnt <= (m_cnt + 1) % (1 << CW);
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_hold && chan_en != 0);
    chk("out_valid", out_valid, m_hold ? (1 << m_tgt) : 0);
    chk("out_data", out_data, m_data);
    chk("sel", sel, m_hold ? m_tgt : m_ptr);
    chk("busy", busy, m_hold);
    chk("sent_cnt", sent_cnt, m_cnt);
    if ((out_valid & out_ready) != 0)
      for (int k = 0; k < 4; k++) if (out_valid[k]) dlog.push_back(k);
  end

  task automatic send(input logic [7:0] d);
    bit acc = 0;
    in_data = d;
    in_valid = 1;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic dlog_chk(input string nm, input logic [31:0] seq, input int n);
    chk({nm, "_len"}, dlog.size(), n);
    for (int i = 0; i < n; i++) chk(nm, (i < dlog.size()) ? dlog[i] : -1, seq[4*i +: 4]);
    dlog.delete();
  endtask

  task automatic pulse_rst;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    int c0;
    rst = 1; in_valid = 0; in_data = 0; chan_en = 4'hF; out_ready = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", sel, 0);
    chk("rst_cnt", sent_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 0;
    // scenario 1: all channels, back-to-back
    c0 = cyc;
    for (int k = 0; k < 8; k++) send(8'h11 + 8'(k));
    @(posedge clk); #1;
    in_valid = 0;
    chk("s1_cycles", cyc - c0, 16);
    chk("s1_cnt", sent_cnt, 8);
    dlog_chk("s1_tgt", 32'h32103210, 8);
    // scenario 2: only channels 1 and 3
    chan_en = 4'b1010;
    for (int k = 0; k < 4; k++) send(8'h20 + 8'(k));
    @(posedge clk); #1;
    in_valid = 0;
    dlog_chk("s2_tgt", 32'h3131, 4);
    // scenario 3: stalled delivery on channel 2, enable dropped mid-wait
    chan_en = 4'hF;
    send(8'h01);
    send(8'h02);
    out_ready = 4'b1011;
    send(8'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s3_hold_valid", out_valid, 4'b0100);
      chk("s3_hold_data", out_data, 8'hA5);
      @(posedge clk); #1;
      if (i == 2) chan_en = 4'b1011;
    end
    out_ready = 4'hF;
    send(8'h5A);
    @(posedge clk); #1;
    in_valid = 0;
    dlog_chk("s3_tgt", 32'h3210, 4);
    // scenario 4: no channel enabled stalls without moving the pointer
    chan_en = 4'b0000;
    in_valid = 1; in_data = 8'h77;
    repeat (3) begin
      @(negedge clk);
      chk("s4_in_ready", in_ready, 0);
      chk("s4_busy", busy, 0);
      chk("s4_sel", sel, 0);
      @(posedge clk); #1;
    end
    chan_en = 4'b0100;
    send(8'h77);
    @(posedge clk); #1;
    in_valid = 0;
    dlog_chk("s4_tgt", 32'h2, 1);
    // scenario 5: reset lands in the middle of HOLD
    chan_en = 4'hF; out_ready = 4'h0;
    send(8'h33);
    #2;
    rst = 1;
    #1;
    chk("s5_valid", out_valid, 0);
    chk("s5_cnt", sent_cnt, 0);
    chk("s5_busy", busy, 0);
    chk("s5_data", out_data, 0);
    @(posedge clk); #1;
    rst = 0; out_ready = 4'hF;
    send(8'h44);
    @(posedge clk); #1;
    in_valid = 0;
    dlog_chk("s5_tgt", 32'h0, 1);
    // scenario 6: counter wrap with a 4-bit counter
    pulse_rst();
    for (int k = 0; k < 17; k++) send(8'(k));
    @(posedge clk); #1;
    in_valid = 0;
    chk("s6_cnt_wrap", sent_cnt, 1);
    chk("s6_sel", sel, 1);
    dlog.delete();
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
